dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: byte-lane RAM with 1-cycle registered loads,
// sticky error flag, optional MMIO window enabled by DMEM_RESPONDER_MMIO_EN.
module dmem_responder #(
  parameter int ADDR_W = 14
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  input  logic        dmemre,
  output logic [31:0] dmemdataout,
  output logic        dmemvalid,
  output logic        dmemerr,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR
);

  localparam int WORDS = 1 << (ADDR_W - 2);

  logic [3:0][7:0]   mem_q [WORDS];
  logic [ADDR_W-3:0] widx;
  logic [1:0]        bsel;

  logic        op_legal, is_h, is_w, misal, acc, bad, ram_we, ld;
  logic        mmio_sel, mmio_bad;
  logic [31:0] mmio_rdata;
  logic [3:0]  be;
  logic [31:0] wdata, rword, rshift, ram_rdata;

  logic [31:0] dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic unused_addr_hi;
  assign unused_addr_hi = ^dmemaddr[31:ADDR_W];

  assign widx = dmemaddr[ADDR_W-1:2];
  assign bsel = dmemaddr[1:0];

  always_comb begin
    op_legal = (dmemop == 3'b000) || (dmemop == 3'b001) || (dmemop == 3'b010) ||
               (dmemop == 3'b100) || (dmemop == 3'b101);
    is_h     = (dmemop[1:0] == 2'b01);
    is_w     = (dmemop == 3'b010);
    misal    = (is_h && dmemaddr[0]) || (is_w && (dmemaddr[1:0] != 2'b00));
    acc      = dmemwe | dmemre;
    bad      = !op_legal || misal || mmio_bad;
    ram_we   = dmemwe && !bad && !mmio_sel;
    ld       = dmemre && !dmemwe;
  end

  // Lane enables and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = dmemdatain;
    case (dmemop[1:0])
      2'b00: begin
        be    = 4'b0001 << bsel;
        wdata = {4{dmemdatain[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {bsel[1], 1'b0};
        wdata = {2{dmemdatain[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = dmemdatain;
      end
    endcase
  end

  // RAM contents deliberately survive reset
  always_ff @(posedge CLOCK_50) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][b] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rword     = mem_q[widx];
    rshift    = rword >> {bsel, 3'b000};
    ram_rdata = rword;
    case (dmemop[1:0])
      2'b00:   ram_rdata = {{24{rshift[7]  & ~dmemop[2]}}, rshift[7:0]};
      2'b01:   ram_rdata = {{16{rshift[15] & ~dmemop[2]}}, rshift[15:0]};
      default: ram_rdata = rword;
    endcase
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [27:0] off;
  logic        off_led, off_sw, off_cnt;
  logic [9:0]  led_q, led_d;
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [31:0] cnt_q, cnt_d;
  logic        mmio_st;

  always_comb begin
    off        = dmemaddr[27:0];
    off_led    = (off == 28'h0);
    off_sw     = (off == 28'h4);
    off_cnt    = (off == 28'h8);
    mmio_sel   = (dmemaddr[31:28] == 4'h8);
    mmio_bad   = mmio_sel && acc && (!is_w || !(off_led || off_sw || off_cnt));
    mmio_st    = dmemwe && mmio_sel && !bad;
    led_d      = (mmio_st && off_led) ? dmemdatain[9:0] : led_q;
    cnt_d      = (mmio_st && off_cnt) ? 32'h0 : cnt_q + 32'h1;
    mmio_rdata = 32'h0;
    if (off_led)      mmio_rdata = {22'h0, led_q};
    else if (off_sw)  mmio_rdata = {22'h0, sw_s2_q};
    else if (off_cnt) mmio_rdata = cnt_q;
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      cnt_q   <= '0;
    end else begin
      led_q   <= led_d;
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign LEDR = led_q;
`else
  logic unused_sw;
  assign unused_sw  = ^SW;
  assign mmio_sel   = 1'b0;
  assign mmio_bad   = 1'b0;
  assign mmio_rdata = 32'h0;
  assign LEDR       = '0;
`endif

  // Erroneous loads still answer, with zero data, so the CPU never waits forever
  always_comb begin
    vld_d  = ld;
    dout_d = dout_q;
    if (ld) dout_d = bad ? 32'h0 : (mmio_sel ? mmio_rdata : ram_rdata);
    err_d  = err_q || (acc && bad) || (dmemwe && dmemre);
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign dmemdataout = dout_q;
  assign dmemvalid   = vld_q;
  assign dmemerr     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard queue of expected load data,
// checked #1 after each rising edge.
module tb_dmem_responder;

  localparam logic [2:0] OB = 3'b000, OH = 3'b001, OW = 3'b010, OBU = 3'b100, OHU = 3'b101;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [31:0] dmemaddr, dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe, dmemre;
  logic [31:0] dmemdataout;
  logic        dmemvalid, dmemerr;
  logic [9:0]  SW, LEDR;

  int total = 0;
  int bad   = 0;
  logic [31:0] expq[$];
  logic [31:0] last_d = 32'h0;

  dmem_responder #(.ADDR_W(14)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .dmemaddr(dmemaddr), .dmemdatain(dmemdatain),
    .dmemop(dmemop), .dmemwe(dmemwe), .dmemre(dmemre), .dmemdataout(dmemdataout),
    .dmemvalid(dmemvalid), .dmemerr(dmemerr), .SW(SW), .LEDR(LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request per edge; a load pushes its expected data, the response is popped after the edge
  task automatic step(input logic we, input logic re, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] din,
                      input logic exp_ld, input logic [31:0] exp_d);
    logic [31:0] d;
    logic        ev;
    dmemwe = we; dmemre = re; dmemop = op; dmemaddr = addr; dmemdatain = din;
    if (exp_ld) expq.push_back(exp_d);
    @(posedge CLOCK_50);
    #1;
    ev = (expq.size() > 0);
    chk("valid", {31'h0, dmemvalid}, {31'h0, ev});
    if (ev) begin
      d = expq.pop_front();
      chk("data", dmemdataout, d);
      last_d = d;
    end else begin
      chk("hold", dmemdataout, last_d);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, OW, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; dmemaddr = '0; dmemdatain = '0; dmemop = OW; dmemwe = 1'b0; dmemre = 1'b0; SW = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_data", dmemdataout, 32'h0);
    chk("rst_valid", {31'h0, dmemvalid}, 32'h0);
    chk("rst_err", {31'h0, dmemerr}, 32'h0);
    chk("rst_led", {22'h0, LEDR}, 32'h0);
    rst = 1'b0;

    // Sign/zero extension across lanes
    step(1, 0, OW,  32'h100, 32'h80FF7F01, 0, 0);
    step(0, 1, OB,  32'h103, 0, 1, 32'hFFFFFF80);
    step(0, 1, OBU, 32'h103, 0, 1, 32'h00000080);
    step(0, 1, OH,  32'h102, 0, 1, 32'hFFFF80FF);
    step(0, 1, OHU, 32'h100, 0, 1, 32'h00007F01);
    step(0, 1, OB,  32'h101, 0, 1, 32'h0000007F);

    // Partial stores, each followed immediately by a load of the new data
    step(1, 0, OW, 32'h20, 32'h11223344, 0, 0);
    step(1, 0, OH, 32'h22, 32'h0000BEEF, 0, 0);
    step(0, 1, OW, 32'h20, 0, 1, 32'hBEEF3344);
    step(1, 0, OB, 32'h21, 32'h0000005A, 0, 0);
    step(0, 1, OW, 32'h20, 0, 1, 32'hBEEF5A44);
    idle();
    idle();
    // High address bits alias onto the 16 KiB RAM
    step(0, 1, OW, 32'h00004100, 0, 1, 32'h80FF7F01);
    chk("err_clean", {31'h0, dmemerr}, 32'h0);

    // Misaligned load answers with zero and latches the error
    step(0, 1, OW, 32'h06, 0, 1, 32'h0);
    chk("err_misal", {31'h0, dmemerr}, 32'h1);
    step(1, 0, OW, 32'h22, 32'hDEADBEEF, 0, 0);
    step(1, 0, OH, 32'h21, 32'h0000FFFF, 0, 0);
    step(0, 1, OW, 32'h20, 0, 1, 32'hBEEF5A44);
    step(0, 1, 3'b011, 32'h20, 0, 1, 32'h0);
    step(0, 1, OHU, 32'h23, 0, 1, 32'h0);
    chk("err_sticky", {31'h0, dmemerr}, 32'h1);

    // Simultaneous store and load: store wins, load is dropped
    step(1, 1, OW, 32'h40, 32'hCAFEF00D, 0, 0);
    step(0, 1, OW, 32'h40, 0, 1, 32'hCAFEF00D);
    idle();
    chk("err_still", {31'h0, dmemerr}, 32'h1);

    // Reset lands while a load response is due
    dmemwe = 0; dmemre = 1; dmemop = OW; dmemaddr = 32'h40;
    @(posedge CLOCK_50);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", {31'h0, dmemvalid}, 32'h0);
    chk("rstmid_data", dmemdataout, 32'h0);
    chk("rstmid_err", {31'h0, dmemerr}, 32'h0);
    @(posedge CLOCK_50);
    #1;
    chk("rsthold_valid", {31'h0, dmemvalid}, 32'h0);
    chk("rsthold_led", {22'h0, LEDR}, 32'h0);
    rst = 1'b0;
    dmemre = 0;
    last_d = 32'h0;
    idle();
    // RAM is not cleared by reset
    step(0, 1, OW, 32'h40, 0, 1, 32'hCAFEF00D);
    step(0, 1, OW, 32'h20, 0, 1, 32'hBEEF5A44);
    chk("err_after_rst", {31'h0, dmemerr}, 32'h0);

`ifdef DMEM_RESPONDER_MMIO_EN
    step(1, 0, OW, 32'h80000000, 32'h000003FF, 0, 0);
    chk("ledr", {22'h0, LEDR}, 32'h3FF);
    step(0, 1, OW, 32'h80000000, 0, 1, 32'h000003FF);
    SW = 10'h155;
    idle();
    idle();
    step(0, 1, OW, 32'h80000004, 0, 1, 32'h00000155);
    step(1, 0, OW, 32'h80000004, 32'h0, 0, 0);
    chk("mmio_sw_store_noerr", {31'h0, dmemerr}, 32'h0);
    // Counter is 0 after the store edge, so the load edge ten cycles later sees 9
    step(1, 0, OW, 32'h80000008, 32'h12345678, 0, 0);
    repeat (9) idle();
    step(0, 1, OW, 32'h80000008, 0, 1, 32'd9);
    step(0, 1, OH, 32'h80000000, 0, 1, 32'h0);
    chk("mmio_err", {31'h0, dmemerr}, 32'h1);
`endif

    idle();
    chk("queue_empty", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
